// File: rtl/div_hilo_ctrl.sv
// rtl/div_hilo_ctrl.sv - HI/LO divide sequencer between execute stage and DIVU/DIV iterative dividers
`timescale 1ns/1ps
module div_hilo_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_start,
  input  logic        div_busy,
  input  logic [31:0] divu_q,
  input  logic [31:0] divu_r,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        dz,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_ARM, S_WAIT} state_t;

  state_t        state;
  logic          sgn;
  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      div_start    <= 1'b0;
      done         <= 1'b0;
      dz           <= 1'b0;
      timeout      <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      sgn          <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      div_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (req_valid) begin
            div_dividend <= req_dividend;
            div_divisor  <= req_divisor;
            sgn          <= req_signed;
            dz           <= 1'b0;
            timeout      <= 1'b0;
            wd_cnt       <= '0;
            // Bypass results are assigned after the direct writes so they win.
            if (req_divisor == 32'h0) begin
              lo   <= 32'hFFFF_FFFF;
              hi   <= req_dividend;
              dz   <= 1'b1;
              done <= 1'b1;
            end else if (req_signed && req_dividend == 32'h8000_0000 &&
                         req_divisor == 32'hFFFF_FFFF) begin
              lo   <= 32'h8000_0000;
              hi   <= 32'h0;
              done <= 1'b1;
            end else begin
              state     <= S_LAUNCH;
              req_ready <= 1'b0;
              div_start <= 1'b1;
            end
          end
        end
        S_LAUNCH: state <= S_ARM;
        S_ARM: begin
          if (wd_cnt == WD_LAST) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            timeout   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (div_busy) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Completion wins over a watchdog expiry on the same edge.
          if (!div_busy) begin
            lo        <= sgn ? div_q : divu_q;
            hi        <= sgn ? div_r : divu_r;
            done      <= 1'b1;
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end else if (wd_cnt == WD_LAST) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            timeout   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/div_hilo_ctrl.md
# div_hilo_ctrl

Sequencer between the CPU execute stage and the DIVU/DIV iterative dividers. It accepts one divide request at a time over a valid/ready handshake and launches the selected divider with a single-cycle start pulse. It waits on the divider's busy, then writes quotient to LO and remainder to HI. Divide-by-zero and signed overflow bypass the divider with fixed results, and a watchdog protects against a divider that never completes.

## Interface
- TIMEOUT, 40: maximum cycles spent in ARM plus WAIT before abort.
- clock  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; all registers cleared while low.
- req_valid  in  1  CPU presents a divide request.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_signed  in  1  1 = DIV (signed), 0 = DIVU (unsigned).
- req_dividend  in  32  dividend.
- req_divisor  in  32  divisor.
- wr_hi, wr_lo  in  1  direct HI/LO write strobes (MTHI/MTLO).
- wr_data  in  32  direct write data.
- div_dividend, div_divisor  out  32  registered operands to both dividers.
- div_start  out  1  one-cycle launch pulse.
- div_busy  in  1  divider busy.
- divu_q, divu_r, div_q, div_r  in  32  unsigned and signed divider results.
- hi, lo  out  32  architectural HI/LO.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- dz  out  1  sticky divide-by-zero flag, cleared on next accepted request.
- timeout  out  1  sticky watchdog abort flag, cleared on next accepted request.

## Operation
- States: IDLE, LAUNCH, ARM, WAIT.
- IDLE: req_ready=1. Accept on req_valid=1 at a clock edge. Latch operands into div_dividend/div_divisor, latch req_signed, clear dz and timeout.
  - divisor==0: bypass. lo<=32'hFFFFFFFF, hi<=req_dividend, dz<=1, done=1 next cycle, stay IDLE.
  - req_signed and dividend==32'h80000000 and divisor==32'hFFFFFFFF: bypass. lo<=32'h80000000, hi<=0, done=1 next cycle, stay IDLE.
  - otherwise: go to LAUNCH.
- LAUNCH: div_start=1 for exactly this cycle. Go to ARM.
- ARM: wait for div_busy=1, then go to WAIT.
- WAIT: on the edge that samples div_busy=0, load results into lo/hi, pulse done, and go to IDLE.
  - Results are q/r from div_* if signed, from divu_* if unsigned.
- Watchdog: a cycle counter is cleared on entry to LAUNCH and increments in ARM and WAIT. When it reaches TIMEOUT, set timeout<=1 and return to IDLE. HI/LO are not written and done is not pulsed.
- Direct writes: wr_hi/wr_lo honoured only in IDLE; ignored in other states.
  - If a write and an accepted request occur together, the write lands that cycle and the division result overwrites it later.
  - A bypass result takes priority over a same-cycle direct write.
- div_dividend/div_divisor hold stable from acceptance until the next acceptance.

## Timing
- Reset values: state IDLE, req_ready=1, div_start=0, done=0, dz=0, timeout=0, hi=lo=0, div_dividend=div_divisor=0.
- Accept at edge N. div_start high in cycle N+1. ARM from N+2.
- If busy falls at edge M, then done=1 and new hi/lo are visible in cycle M+1, and req_ready=1 from M+1.
- Bypass latency: accept at edge N, done and hi/lo visible in cycle N+1, req_ready stays 1.
- Back-to-back: a request can be accepted in the same cycle that done is high.
- Reset low mid-operation: immediate return to reset values. No done pulse and no HI/LO write.
- div_busy high in IDLE is ignored.

## Test plan
- Unsigned 32'hFFFFFFFF / 32'h2 with a behavioural divider (busy for 33 cycles) -> lo=32'h7FFFFFFF, hi=32'h1, single done pulse, exactly one div_start pulse.
- Signed 32'hFFFFFFFF / 32'h2 -> lo=32'h0, hi=32'hFFFFFFFF. Signed 32'hAAAAAAAA / 32'h55555555 -> lo=32'hFFFFFFFF, hi=32'hFFFFFFFF. Unsigned same operands -> lo=32'h2, hi=32'h0.
- Divisor 0, dividend 32'h12345678 -> done in cycle N+1, lo=32'hFFFFFFFF, hi=32'h12345678, dz=1, div_start never asserted. Signed 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0, dz=0.
- Divider model holds busy high forever -> timeout=1 after TIMEOUT cycles, hi/lo unchanged, no done, req_ready=1 afterwards, next request clears timeout.
- reset low during WAIT -> all outputs return to reset values asynchronously. Next request after release completes normally.
- wr_hi=1 with wr_data=32'hDEADBEEF in IDLE -> hi=32'hDEADBEEF next cycle. Same strobe during WAIT -> hi unchanged.
